// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and defaults.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CW_DEFAULT      = 4;

endpackage

// File: rtl/timeout_counter.sv
// Busy-cycle counter for the arbiter; flags the last cycle allowed before an abort.
module timeout_counter #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count waited cycles; clear has priority so each new access starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data ports.
// Data requests win ties because they belong to the older instruction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             stall_f,
  output logic             stall_m,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             err
);

  state_t state;
  logic   busy;
  logic   timed_out;

  assign busy = (state != IDLE);

  timeout_counter #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && !mem_ready),
    .terminal(timed_out)
  );

  // Hold each requester until its completion pulse arrives.
  assign stall_f = i_req & ~i_done;
  assign stall_m = d_req & ~d_done;

  // Arbiter FSM: issue one access, wait for ready or timeout, then report completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req && !d_done) begin
            state     <= DBUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_req && !i_done) begin
            state    <= IBUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        DBUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end else if (timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_done  <= 1'b1;
            d_rdata <= '0;
            err     <= 1'b1;
          end
        end
        IBUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_done  <= 1'b1;
            i_rdata <= mem_rdata;
          end else if (timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_done  <= 1'b1;
            i_rdata <= '0;
            err     <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  typedef struct packed {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_req = 1'b0;
  logic [WIDTH-1:0] i_addr = '0;
  logic [WIDTH-1:0] i_rdata;
  logic             i_done;
  logic             d_req = 1'b0;
  logic             d_we = 1'b0;
  logic [WIDTH-1:0] d_addr = '0;
  logic [WIDTH-1:0] d_wdata = '0;
  logic [WIDTH-1:0] d_rdata;
  logic             d_done;
  logic             stall_f;
  logic             stall_m;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             mem_ready = 1'b0;
  logic             err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem [64];

  mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  task automatic test_reset();
    logic [31:0] got [10];
    string names [10];
    repeat (2) @(negedge clk);
    got = '{32'(mem_req), 32'(mem_we), 32'(i_done), 32'(d_done), 32'(err),
            mem_addr, mem_wdata, i_rdata, d_rdata, 32'(stall_f)};
    names = '{"reset_mem_req", "reset_mem_we", "reset_i_done", "reset_d_done", "reset_err",
              "reset_mem_addr", "reset_mem_wdata", "reset_i_rdata", "reset_d_rdata", "reset_stall_f"};
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (got[k] !== 32'h0) begin miscompares++; $display("[TB] FAIL %s: got %0h, expected 0", names[k], got[k]); end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h40; mem_ready = 1'b0;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_mem_req: got %0h, expected 1", mem_req); end
    vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("[TB] FAIL fetch_mem_addr: got %0h, expected 40", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_mem_we: got %0h, expected 0", mem_we); end
    vectors++; if (stall_f !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_stall_busy: got %0h, expected 1", stall_f); end
    @(negedge clk);
    vectors++; if (i_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_early_done: got %0h, expected 0", i_done); end
    mem_ready = 1'b1; mem_rdata = 32'h2002_0005;
    @(negedge clk);
    vectors++; if (i_done !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_done: got %0h, expected 1", i_done); end
    vectors++; if (i_rdata !== 32'h2002_0005) begin miscompares++; $display("[TB] FAIL fetch_rdata: got %0h, expected 20020005", i_rdata); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_mem_req_drop: got %0h, expected 0", mem_req); end
    vectors++; if (stall_f !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_stall_done: got %0h, expected 0", stall_f); end
    i_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    vectors++; if (i_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_done_pulse: got %0h, expected 0", i_done); end
    vectors++; if (i_rdata !== 32'h2002_0005) begin miscompares++; $display("[TB] FAIL fetch_rdata_hold: got %0h, expected 20020005", i_rdata); end
  endtask

  task automatic test_collision();
    int d_cyc = -1, i_cyc = -1, d_cnt = 0, i_cnt = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h54;
    i_req = 1'b1; i_addr = 32'h44;
    mem_ready = 1'b1; mem_rdata = pat(mem_addr);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (d_done) begin
        d_cnt++;
        if (d_cnt == 1) begin
          d_cyc = cyc;
          vectors++; if (d_rdata !== pat(32'h54)) begin miscompares++; $display("[TB] FAIL coll_d_rdata: got %0h, expected %0h", d_rdata, pat(32'h54)); end
        end
        d_req = 1'b0;
      end
      if (i_done) begin
        i_cnt++;
        if (i_cnt == 1) begin
          i_cyc = cyc;
          vectors++; if (i_rdata !== pat(32'h44)) begin miscompares++; $display("[TB] FAIL coll_i_rdata: got %0h, expected %0h", i_rdata, pat(32'h44)); end
        end
        i_req = 1'b0;
      end
      mem_rdata = pat(mem_addr);
    end
    mem_ready = 1'b0;
    exp_d_rdata = pat(32'h54);
    vectors++; if (d_cyc !== 2) begin miscompares++; $display("[TB] FAIL coll_d_cycle: got %0d, expected 2", d_cyc); end
    vectors++; if (i_cyc !== 4) begin miscompares++; $display("[TB] FAIL coll_i_cycle: got %0d, expected 4", i_cyc); end
    vectors++; if (d_cnt !== 1) begin miscompares++; $display("[TB] FAIL coll_d_count: got %0d, expected 1", d_cnt); end
    vectors++; if (i_cnt !== 1) begin miscompares++; $display("[TB] FAIL coll_i_count: got %0d, expected 1", i_cnt); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL store_mem_req: got %0h, expected 1", mem_req); end
      vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL store_mem_we: got %0h, expected 1", mem_we); end
      vectors++; if (mem_wdata !== 32'h7) begin miscompares++; $display("[TB] FAIL store_mem_wdata: got %0h, expected 7", mem_wdata); end
      vectors++; if (mem_addr !== 32'h54) begin miscompares++; $display("[TB] FAIL store_mem_addr: got %0h, expected 54", mem_addr); end
      vectors++; if (stall_m !== 1'b1) begin miscompares++; $display("[TB] FAIL store_stall_busy: got %0h, expected 1", stall_m); end
      if (k == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    vectors++; if (d_done !== 1'b1) begin miscompares++; $display("[TB] FAIL store_done: got %0h, expected 1", d_done); end
    vectors++; if (d_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL store_rdata_kept: got %0h, expected %0h", d_rdata, exp_d_rdata); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL store_mem_we_drop: got %0h, expected 0", mem_we); end
    vectors++; if (stall_m !== 1'b0) begin miscompares++; $display("[TB] FAIL store_stall_done: got %0h, expected 0", stall_m); end
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    vectors++; if (d_done !== 1'b0) begin miscompares++; $display("[TB] FAIL store_done_pulse: got %0h, expected 0", d_done); end
  endtask

  task automatic test_ready_vs_timeout();
    i_req = 1'b1; i_addr = 32'h88; mem_ready = 1'b0; mem_rdata = 32'hCAFE_0001;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(negedge clk);
      vectors++; if (i_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rvt_early_done: got %0h, expected 0 at cycle %0d", i_done, cyc); end
      if (cyc == TIMEOUT) mem_ready = 1'b1;
    end
    @(negedge clk);
    vectors++; if (i_done !== 1'b1) begin miscompares++; $display("[TB] FAIL rvt_done: got %0h, expected 1", i_done); end
    vectors++; if (i_rdata !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL rvt_rdata: got %0h, expected cafe0001", i_rdata); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rvt_err: got %0h, expected 0", err); end
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int done_cyc = -1;
    int cyc = 0;
    i_req = 1'b1; i_addr = 32'h8C; mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
    while (done_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (i_done) done_cyc = cyc;
    end
    vectors++; if (done_cyc !== TIMEOUT + 1) begin miscompares++; $display("[TB] FAIL timeout_cycle: got %0d, expected %0d", done_cyc, TIMEOUT + 1); end
    vectors++; if (i_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL timeout_rdata: got %0h, expected 0", i_rdata); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %0h, expected 1", err); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_mem_req: got %0h, expected 0", mem_req); end
    i_req = 1'b0;
    @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err_sticky: got %0h, expected 1", err); end
    vectors++; if (i_done !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_done_pulse: got %0h, expected 0", i_done); end
  endtask

  task automatic test_reset_mid_op();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; mem_ready = 1'b0;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_busy: got %0h, expected 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_mem_req: got %0h, expected 0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rmid_mem_addr: got %0h, expected 0", mem_addr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_err: got %0h, expected 0", err); end
    vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rmid_d_rdata: got %0h, expected 0", d_rdata); end
    vectors++; if (d_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_d_done: got %0h, expected 0", d_done); end
    exp_d_rdata = '0;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h24; mem_ready = 1'b1; mem_rdata = 32'h1357_2468;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_new_req: got %0h, expected 1", mem_req); end
    @(negedge clk);
    vectors++; if (i_done !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_new_done: got %0h, expected 1", i_done); end
    vectors++; if (i_rdata !== 32'h1357_2468) begin miscompares++; $display("[TB] FAIL rmid_new_rdata: got %0h, expected 13572468", i_rdata); end
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(input int n, input logic exp_err);
    for (int k = 0; k < 64; k++) begin
      logic [31:0] v;
      v = $urandom;
      tb_mem[k] = v;
      ref_mem[k] = v;
    end
    for (int t = 0; t < n; t++) begin
      acc_t q[$];
      acc_t da, ia;
      int kind, cyc, first_seen, delay, wait_cnt, start_exp;
      bit active;
      kind = $urandom_range(0, 2);
      da = '{is_data: 1'b1, we: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 63)) << 2, wdata: $urandom};
      ia = '{is_data: 1'b0, we: 1'b0, addr: 32'($urandom_range(0, 63)) << 2, wdata: 32'h0};
      if (kind != 0) q.push_back(da);
      if (kind != 1) q.push_back(ia);
      if (kind != 0) begin d_req = 1'b1; d_we = da.we; d_addr = da.addr; d_wdata = da.wdata; end
      if (kind != 1) begin i_req = 1'b1; i_addr = ia.addr; end
      mem_ready = 1'b0;
      start_exp = 1; active = 0; wait_cnt = 0; cyc = 0; first_seen = 0; delay = 0;
      while (q.size() > 0 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (d_done) begin
          vectors++;
          if (q.size() == 0 || !q[0].is_data) begin
            miscompares++; $display("[TB] FAIL rand_d_order: got d_done at cycle %0d, expected no data completion", cyc);
          end else begin
            if (cyc !== first_seen + delay + 1) begin miscompares++; $display("[TB] FAIL rand_d_latency: got cycle %0d, expected %0d", cyc, first_seen + delay + 1); end
            if (q[0].we) ref_mem[q[0].addr[7:2]] = q[0].wdata;
            else exp_d_rdata = ref_mem[q[0].addr[7:2]];
            vectors++; if (d_rdata !== exp_d_rdata) begin miscompares++; $display("[TB] FAIL rand_d_rdata: got %0h, expected %0h", d_rdata, exp_d_rdata); end
            vectors++; if (stall_m !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_stall_m_done: got %0h, expected 0", stall_m); end
            d_req = 1'b0; void'(q.pop_front()); start_exp = cyc + 1; active = 0;
          end
        end
        if (i_done) begin
          vectors++;
          if (q.size() == 0 || q[0].is_data) begin
            miscompares++; $display("[TB] FAIL rand_i_order: got i_done at cycle %0d, expected no fetch completion", cyc);
          end else begin
            if (cyc !== first_seen + delay + 1) begin miscompares++; $display("[TB] FAIL rand_i_latency: got cycle %0d, expected %0d", cyc, first_seen + delay + 1); end
            vectors++; if (i_rdata !== ref_mem[q[0].addr[7:2]]) begin miscompares++; $display("[TB] FAIL rand_i_rdata: got %0h, expected %0h", i_rdata, ref_mem[q[0].addr[7:2]]); end
            vectors++; if (stall_f !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_stall_f_done: got %0h, expected 0", stall_f); end
            i_req = 1'b0; void'(q.pop_front()); start_exp = cyc + 1; active = 0;
          end
        end
        if (mem_req) begin
          if (!active) begin
            active = 1; first_seen = cyc; delay = $urandom_range(0, 3); wait_cnt = 0;
            vectors++;
            if (q.size() == 0) begin
              miscompares++; $display("[TB] FAIL rand_spurious_req: got mem_req at cycle %0d, expected idle", cyc);
            end else begin
              if (first_seen !== start_exp) begin miscompares++; $display("[TB] FAIL rand_issue_cycle: got %0d, expected %0d", first_seen, start_exp); end
              vectors++; if (mem_addr !== q[0].addr) begin miscompares++; $display("[TB] FAIL rand_mem_addr: got %0h, expected %0h", mem_addr, q[0].addr); end
              vectors++; if (mem_we !== q[0].we) begin miscompares++; $display("[TB] FAIL rand_mem_we: got %0h, expected %0h", mem_we, q[0].we); end
              if (q[0].we) begin
                vectors++; if (mem_wdata !== q[0].wdata) begin miscompares++; $display("[TB] FAIL rand_mem_wdata: got %0h, expected %0h", mem_wdata, q[0].wdata); end
              end
            end
          end
          if (wait_cnt == delay) begin
            mem_ready = 1'b1;
            mem_rdata = tb_mem[mem_addr[7:2]];
            if (mem_we) tb_mem[mem_addr[7:2]] = mem_wdata;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
          end
        end else begin
          mem_ready = 1'b0;
        end
        if (d_req) begin
          vectors++; if (stall_m !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_stall_m_wait: got %0h, expected 1", stall_m); end
        end
        if (i_req) begin
          vectors++; if (stall_f !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_stall_f_wait: got %0h, expected 1", stall_f); end
        end
      end
      vectors++;
      if (q.size() != 0) begin miscompares++; $display("[TB] FAIL rand_hang: got %0d pending accesses, expected 0", q.size()); end
      d_req = 1'b0; i_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      vectors++; if (err !== exp_err) begin miscompares++; $display("[TB] FAIL rand_err: got %0h, expected %0h", err, exp_err); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_store();
    test_ready_vs_timeout();
    test_timeout();
    test_random(20, 1'b1);
    test_reset_mid_op();
    test_random(30, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
